// File: rtl/neosd_clk_gen_if.sv
// SD clock generator interface: divider and gating controls in; strobe, enable and pin clock out.
// Latency: none (wires only).
// Backpressure: none. The FSM side stalls the SD clock through sd_clk_stall_i.
// Optional macro NEOSD_CLK_FORCE_EN adds force_clk_i for the card power-up clocking.
interface neosd_clk_gen_if #(
  parameter int DIV_W = 8
);
  logic [DIV_W-1:0] div_i;
  logic             sd_clk_req_i;
  logic             sd_clk_stall_i;
`ifdef NEOSD_CLK_FORCE_EN
  logic             force_clk_i;
`endif
  logic             clkstrb_o;
  logic             sd_clk_en_o;
  logic             sd_clk_o;

  // Master: the controlling FSM side.
  modport master (
`ifdef NEOSD_CLK_FORCE_EN
    output force_clk_i,
`endif
    output div_i, sd_clk_req_i, sd_clk_stall_i,
    input  clkstrb_o, sd_clk_en_o, sd_clk_o
  );

  // Slave: the clock generator itself.
  modport slave (
`ifdef NEOSD_CLK_FORCE_EN
    input  force_clk_i,
`endif
    input  div_i, sd_clk_req_i, sd_clk_stall_i,
    output clkstrb_o, sd_clk_en_o, sd_clk_o
  );
endinterface

// File: rtl/neosd_clk_gen.sv
// SD card clock divider, free-running bit strobe and glitch-free clock gate.
// Latency: clkstrb_o comes straight from registers; gating requests take effect at the next low-half end.
// Backpressure: sd_clk_stall_i holds the SD clock low while the strobes keep running.
// Optional macro NEOSD_CLK_FORCE_EN adds force_clk_i, which runs the clock with no FSM active.
module neosd_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  neosd_clk_gen_if.slave      bus
);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  phase_t           r_phase;
  phase_t           w_phase_nxt;
  logic             r_sd_clk;
  logic             w_sd_clk_nxt;
  logic             w_tick;
  logic             w_run;
  logic             w_strb;

  // A half period ends when the down-counter has run out.
  assign w_tick = (r_cnt == '0);

`ifdef NEOSD_CLK_FORCE_EN
  assign w_run = bus.force_clk_i || (bus.sd_clk_req_i && !bus.sd_clk_stall_i);
`else
  assign w_run = bus.sd_clk_req_i && !bus.sd_clk_stall_i;
`endif

  // The strobe marks the falling-edge point. It is decoded from registers only, so no input reaches it.
  assign w_strb          = w_tick && (r_phase == PH_HIGH);
  assign bus.clkstrb_o   = w_strb;
  assign bus.sd_clk_en_o = w_strb && r_sd_clk;
  assign bus.sd_clk_o    = r_sd_clk;

  // Next-state logic. div_i is sampled only at reload, so a running half keeps its length.
  // Gating changes only at the end of a low half, so a high pulse is never shortened.
  always_comb begin
    w_cnt_nxt    = r_cnt - CNT_ONE;
    w_phase_nxt  = r_phase;
    w_sd_clk_nxt = r_sd_clk;
    if (w_tick) begin
      w_cnt_nxt = bus.div_i;
      if (r_phase == PH_LOW) begin
        w_phase_nxt  = PH_HIGH;
        w_sd_clk_nxt = w_run;
      end else begin
        w_phase_nxt  = PH_LOW;
        w_sd_clk_nxt = 1'b0;
      end
    end
  end

  // State registers. Reset drops the SD clock at once, with no attempt to finish a pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt    <= '0;
      r_phase  <= PH_LOW;
      r_sd_clk <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_phase  <= w_phase_nxt;
      r_sd_clk <= w_sd_clk_nxt;
    end
  end

endmodule

// File: tb/tb_neosd_clk_gen.sv
// Directed bench for neosd_clk_gen: an event-level reference model feeds a scoreboard queue,
// and the bench also checks fixed spot values (first strobe cycle, pulse counts, strobe gaps).
module tb_neosd_clk_gen;

  logic clk_i;
  logic rstn_i;

  neosd_clk_gen_if #(.DIV_W(8)) bus ();

  neosd_clk_gen #(.DIV_W(8)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic c;
    logic s;
    logic e;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycle index, cycle of the next half-period end, phase and gated clock level.
  int k;
  int nt;
  bit ph;
  bit mclk;

  // Observation counters, cleared per test.
  int n_strb, n_en, n_hi, first_strb, last_strb, last_gap;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_obs();
    n_strb = 0; n_en = 0; n_hi = 0;
    first_strb = -1; last_strb = -1; last_gap = -1;
  endtask

  task automatic model_reset();
    k = 0; nt = 0; ph = 1'b0; mclk = 1'b0;
    q.delete();
  endtask

  // Assert reset, release it mid-cycle (that cycle is cycle 0), then check the reset outputs.
  task automatic do_reset(input string tag);
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 rstn_i = 1'b1;
    model_reset();
    clr_obs();
    chk({tag, ".rst_clk"},  bus.sd_clk_o,    1'b0);
    chk({tag, ".rst_strb"}, bus.clkstrb_o,   1'b0);
    chk({tag, ".rst_en"},   bus.sd_clk_en_o, 1'b0);
  endtask

  // Drive one cycle of stimulus, push the model's expectation for the next cycle,
  // then step the clock and compare what the DUT presents.
  task automatic cyc(input int d, input bit req, input bit stall, input bit frc, input string tag);
    bit   run;
    exp_t e;
    exp_t g;
    bus.div_i          = d[7:0];
    bus.sd_clk_req_i   = req;
    bus.sd_clk_stall_i = stall;
`ifdef NEOSD_CLK_FORCE_EN
    bus.force_clk_i    = frc;
`endif
    run = frc || (req && !stall);
    if (k == nt) begin
      mclk = ph ? 1'b0 : run;
      ph   = !ph;
      nt   = k + d + 1;
    end
    k++;
    e.s = (k == nt) && ph;
    e.c = mclk;
    e.e = e.s && mclk;
    q.push_back(e);
    @(posedge clk_i);
    #1;
    g = q.pop_front();
    chk({tag, ".clk"},  bus.sd_clk_o,    g.c);
    chk({tag, ".strb"}, bus.clkstrb_o,   g.s);
    chk({tag, ".en"},   bus.sd_clk_en_o, g.e);
    if (bus.clkstrb_o === 1'b1) begin
      if (first_strb < 0) first_strb = k;
      if (last_strb >= 0) last_gap = k - last_strb;
      last_strb = k;
      n_strb++;
    end
    if (bus.sd_clk_en_o === 1'b1) n_en++;
    if (bus.sd_clk_o === 1'b1) n_hi++;
  endtask

  initial begin
    int guard;
    rstn_i             = 1'b0;
    bus.div_i          = '0;
    bus.sd_clk_req_i   = 1'b0;
    bus.sd_clk_stall_i = 1'b0;
`ifdef NEOSD_CLK_FORCE_EN
    bus.force_clk_i    = 1'b0;
`endif

    // T1: div=0, clock requested: pin toggles every cycle, strobe and enable on every high cycle.
    do_reset("T1");
    for (int i = 0; i < 12; i++) cyc(0, 1'b1, 1'b0, 1'b0, "T1");
    chk_int("T1.n_en", n_en, 6);
    chk_int("T1.n_hi", n_hi, 6);

    // T2: div=3, no request: strobes every 8 cycles from cycle 4, pin stays low.
    do_reset("T2");
    for (int i = 0; i < 20; i++) cyc(3, 1'b0, 1'b0, 1'b0, "T2");
    chk_int("T2.first_strb", first_strb, 4);
    chk_int("T2.n_strb", n_strb, 3);
    chk_int("T2.n_hi", n_hi, 0);
    chk_int("T2.n_en", n_en, 0);

    // T3: request raised in cycle 15 (low half ends at 16), dropped in cycle 18: exactly one 4-cycle pulse.
    do_reset("T3");
    for (int i = 0; i < 32; i++) cyc(3, (i >= 15 && i <= 17), 1'b0, 1'b0, "T3");
    chk_int("T3.n_hi", n_hi, 4);
    chk_int("T3.n_en", n_en, 1);

    // T4: div changes 3->1 in cycle 6, mid low half: that half stays 4 cycles, strobes at 4,10,14,18.
    do_reset("T4");
    for (int i = 0; i < 20; i++) cyc((i < 6) ? 3 : 1, 1'b1, 1'b0, 1'b0, "T4");
    chk_int("T4.first_strb", first_strb, 4);
    chk_int("T4.n_strb", n_strb, 4);
    chk_int("T4.gap", last_gap, 4);
    chk_int("T4.last_strb", last_strb, 18);

    // T5: div=1, req and stall both high for three strobes, then the stall is released.
    do_reset("T5");
    for (int i = 0; i < 12; i++) cyc(1, 1'b1, 1'b1, 1'b0, "T5s");
    chk_int("T5.stall_strb", n_strb, 3);
    chk_int("T5.stall_en", n_en, 0);
    chk_int("T5.stall_hi", n_hi, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1'b1, 1'b0, 1'b0, "T5r");
    chk_int("T5.run_en", n_en, 1);
    chk_int("T5.run_strb", last_strb, 14);

    // T6: reset asserted while the pin is high drops it in the same cycle; then restart.
    do_reset("T6");
    guard = 0;
    do begin
      cyc(2, 1'b1, 1'b0, 1'b0, "T6a");
      guard++;
    end while (bus.sd_clk_o !== 1'b1 && guard < 20);
    chk("T6.pin_high_before_rst", bus.sd_clk_o, 1'b1);
    #2 rstn_i = 1'b0;
    #1 chk("T6.async_drop", bus.sd_clk_o, 1'b0);
    @(posedge clk_i);
    #3 rstn_i = 1'b1;
    model_reset();
    clr_obs();
    chk("T6.rel_clk", bus.sd_clk_o, 1'b0);
    chk("T6.rel_strb", bus.clkstrb_o, 1'b0);
    for (int i = 0; i < 10; i++) cyc(2, 1'b0, 1'b0, 1'b0, "T6b");
    chk_int("T6.first_strb", first_strb, 3);

`ifdef NEOSD_CLK_FORCE_EN
    // Forced power-up clocking: 160 cycles at div=0 give 80 real pulses with no request.
    do_reset("T6f");
    for (int i = 0; i < 160; i++) cyc(0, 1'b0, 1'b0, 1'b1, "T6f");
    chk_int("T6f.n_en", n_en, 80);
    chk_int("T6f.n_hi", n_hi, 80);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
